// File: rtl/data_memory_pkg.sv
// Shared types and width helpers for the byte-enabled data memory.
package data_memory_pkg;

  typedef enum logic {ST_INIT, ST_RUN} mem_state_t;

  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-enabled single-port synchronous RAM with registered read; contents are not reset.
module data_mem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                clock,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we && wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_be.sv
// Data memory with valid/ready requests, byte-enable writes, 1-cycle responses and post-reset zero-fill.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; exactly one
// rsp_valid pulse follows on the next cycle, and responses cannot be back-pressured.
module data_memory_be
  import data_memory_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 256,
  parameter int BYTE_ADDR = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done,
  output mem_state_t          dbg_state
);

  localparam int OFF_W = off_width(DATA_W);
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  mem_state_t          state;
  logic [IDX_W-1:0]    fill_idx;
  logic                rsp_is_read;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W-1:0]   addr_hi;
  logic                misaligned;
  logic                addr_err;
  logic                accept;
  logic                arr_we;
  logic [DATA_W/8-1:0] arr_wstrb;
  logic [IDX_W-1:0]    arr_idx;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  // Any word-address bit above the index range means the access is outside the array.
  assign word_addr  = (BYTE_ADDR != 0) ? (req_addr >> OFF_W) : req_addr;
  assign addr_hi    = word_addr >> IDX_W;
  assign misaligned = (BYTE_ADDR != 0) && ((req_addr & OFF_MASK) != '0);
  assign addr_err   = (addr_hi != '0) || misaligned;
  assign accept     = req_valid && req_ready;

  always_comb begin
    arr_we    = 1'b0;
    arr_wstrb = '1;
    arr_idx   = fill_idx;
    arr_wdata = '0;
    if (state == ST_INIT) begin
      arr_we = 1'b1;
    end else begin
      arr_we    = accept && req_write && !addr_err;
      arr_wstrb = req_wstrb;
      arr_idx   = word_addr[IDX_W-1:0];
      arr_wdata = req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      fill_idx    <= '0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_is_read <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          rsp_valid   <= 1'b0;
          rsp_err     <= 1'b0;
          rsp_is_read <= 1'b0;
          if (fill_idx == LAST_IDX) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            fill_idx <= fill_idx + 1'b1;
          end
        end
        default: begin
          rsp_valid   <= accept;
          rsp_err     <= accept && addr_err;
          rsp_is_read <= accept && !req_write && !addr_err;
        end
      endcase
    end
  end

  // RAM output is only meaningful after an accepted good read; otherwise force zero.
  assign rsp_rdata = rsp_is_read ? arr_rdata : '0;
  assign dbg_state = state;

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .wstrb (arr_wstrb),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_memory_be.sv
// Directed table-driven bench for data_memory_be with DATA_W=64, DEPTH=16, byte addressing.
module tb_data_memory_be;
  import data_memory_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 16;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        req_wstrb;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;
  mem_state_t        dbg_state;

  int tests_run;
  int tests_failed;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wstrb;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  data_memory_be #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BYTE_ADDR (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic e, input logic [63:0] r);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_err = e; v.exp_rdata = r;
    vecs.push_back(v);
  endtask

  // Drive one request, then sample its response just after the accepting edge.
  task automatic drive_req(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  // Counts edges after reset release until req_ready rises (bounded).
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (req_ready !== 1'b1) check({name, "_init_done_early"}, 64'(init_done), 64'd0);
    end
    check({name, "_init_cycles"}, 64'(n), 64'd16);
    check({name, "_init_done"}, 64'(init_done), 64'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    idle();

    #23;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_init_done", 64'(init_done), 64'd0);

    @(negedge clock);
    reset_n = 1'b1;
    wait_init("first");

    for (int i = 0; i < DEPTH; i++) add_vec(1'b0, 64'(i * 8), 64'd0, 8'h00, 1'b0, 64'd0);
    add_vec(1'b1, 64'h08, 64'h1122334455667788, 8'hFF, 1'b0, 64'd0);
    add_vec(1'b0, 64'h08, 64'd0, 8'h00, 1'b0, 64'h1122334455667788);
    add_vec(1'b1, 64'h08, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 64'd0);
    add_vec(1'b0, 64'h08, 64'd0, 8'h00, 1'b0, 64'h11223344AAAAAAAA);
    add_vec(1'b0, 64'h0C, 64'd0, 8'h00, 1'b1, 64'd0);
    add_vec(1'b1, 64'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 64'd0);
    add_vec(1'b0, 64'h08, 64'd0, 8'h00, 1'b0, 64'h11223344AAAAAAAA);
    add_vec(1'b1, 64'h8000000000000008, 64'h5555555555555555, 8'hFF, 1'b1, 64'd0);
    add_vec(1'b0, 64'h8000000000000008, 64'd0, 8'h00, 1'b1, 64'd0);
    add_vec(1'b1, 64'h09, 64'h5555555555555555, 8'hFF, 1'b1, 64'd0);
    add_vec(1'b0, 64'h08, 64'd0, 8'h00, 1'b0, 64'h11223344AAAAAAAA);
    add_vec(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 64'd0);
    add_vec(1'b0, 64'h10, 64'd0, 8'h00, 1'b0, 64'd0);
    add_vec(1'b1, 64'h78, 64'hCAFEF00DDEADBEEF, 8'hF0, 1'b0, 64'd0);
    add_vec(1'b0, 64'h78, 64'd0, 8'h00, 1'b0, 64'hCAFEF00D00000000);

    foreach (vecs[k]) begin
      drive_req(vecs[k].write, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb);
      check($sformatf("vec%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
      check($sformatf("vec%0d_rsp_err", k), 64'(rsp_err), 64'(vecs[k].exp_err));
      check($sformatf("vec%0d_rsp_rdata", k), rsp_rdata, vecs[k].exp_rdata);
    end

    idle();
    @(posedge clock);
    #1;
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_rsp_err", 64'(rsp_err), 64'd0);
    check("idle_rsp_rdata", rsp_rdata, 64'd0);

    // 16 writes followed by 16 reads with valid held high throughout
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(1'b1, 64'(i * 8), 64'(i), 8'hFF);
      check($sformatf("b2b_wr%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("b2b_wr%0d_rdata", i), rsp_rdata, 64'd0);
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < DEPTH; i++) begin
      logic [63:0] e;
      drive_req(1'b0, 64'(i * 8), 64'd0, 8'h00);
      e = exp_q.pop_front();
      check($sformatf("b2b_rd%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("b2b_rd%0d_rdata", i), rsp_rdata, e);
    end
    idle();

    // reset while a read response is pending
    drive_req(1'b0, 64'h08, 64'd0, 8'h00);
    check("pend_rsp_valid", 64'(rsp_valid), 64'd1);
    check("pend_rsp_rdata", rsp_rdata, 64'd1);
    idle();
    reset_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midreset_rsp_rdata", rsp_rdata, 64'd0);
    check("midreset_req_ready", 64'(req_ready), 64'd0);
    check("midreset_init_done", 64'(init_done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("second");
    drive_req(1'b0, 64'h08, 64'd0, 8'h00);
    check("post_reset_valid", 64'(rsp_valid), 64'd1);
    check("post_reset_rdata", rsp_rdata, 64'd0);
    drive_req(1'b0, 64'h78, 64'd0, 8'h00);
    check("post_reset_last_rdata", rsp_rdata, 64'd0);
    idle();
    @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
